// File: rtl/pwm_dec_pkg.sv
// rtl/pwm_dec_pkg.sv - shared types and constants for the PWM duty decoder
package pwm_dec_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam int CNT_W_DEF = 9;

    // Counter saturation value: the longest period that can still be measured.
    function automatic int unsigned cnt_max(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// rtl/pwm_sync_edge.sv - multi-flop input synchronizer with rising-edge detect
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// rtl/pwm_duty_decoder.sv - PWM high-time/period measurement with stuck detect
// Optional complement check enabled by defining PWM_DEC_NEG_CHECK_EN.
module pwm_duty_decoder
    import pwm_dec_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int NEG_TOL     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    input  logic             pwm_neg_in,
    output logic [CNT_W-1:0] duty_out,
    output logic [CNT_W-1:0] period_out,
    output logic             valid_out,
    output logic             stuck_out,
    output logic             level_out,
    output logic             neg_err_out
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic             pwm_s;
    logic             rise;
    state_t           state;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic             expired;

    pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pwm_sync (
        .clk   (clk),
        .reset (reset),
        .sig   (pwm_in),
        .level (pwm_s),
        .rise  (rise)
    );

    // Counters saturate at CNT_MAX; 'expired' keeps the timeout strobe to one pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            period_cnt <= '0;
            high_cnt   <= '0;
            expired    <= 1'b0;
            duty_out   <= '0;
            period_out <= '0;
            valid_out  <= 1'b0;
            stuck_out  <= 1'b0;
            level_out  <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            level_out <= pwm_s;
            if (rise) begin
                if (state == MEASURE) begin
                    period_out <= period_cnt;
                    duty_out   <= high_cnt;
                    valid_out  <= 1'b1;
                    stuck_out  <= 1'b0;
                end
                state      <= MEASURE;
                period_cnt <= CNT_W'(1);
                high_cnt   <= CNT_W'(1);
                expired    <= 1'b0;
            end else if (period_cnt == CNT_MAX) begin
                if (!expired) begin
                    period_out <= '0;
                    duty_out   <= pwm_s ? CNT_MAX : '0;
                    valid_out  <= 1'b1;
                    stuck_out  <= 1'b1;
                    state      <= IDLE;
                    expired    <= 1'b1;
                end
            end else begin
                period_cnt <= period_cnt + CNT_W'(1);
                if (state == MEASURE && pwm_s) begin
                    high_cnt <= high_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef PWM_DEC_NEG_CHECK_EN
    localparam logic [7:0] NEG_LIM = 8'(NEG_TOL);

    logic       neg_s;
    logic       unused_neg_rise;
    logic [7:0] neg_cnt;

    pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_neg_sync (
        .clk   (clk),
        .reset (reset),
        .sig   (pwm_neg_in),
        .level (neg_s),
        .rise  (unused_neg_rise)
    );

    // A single equal cycle from edge skew never reaches the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            neg_cnt     <= '0;
            neg_err_out <= 1'b0;
        end else if (pwm_s == neg_s) begin
            if (neg_cnt != 8'hff) begin
                neg_cnt <= neg_cnt + 8'd1;
            end
            if (neg_cnt >= NEG_LIM) begin
                neg_err_out <= 1'b1;
            end
        end else begin
            neg_cnt <= '0;
        end
    end
`else
    localparam int unused_neg_tol = NEG_TOL;
    logic unused_neg;
    assign unused_neg  = pwm_neg_in;
    assign neg_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb/tb_pwm_duty_decoder.sv - directed self-checking bench for pwm_duty_decoder
module tb_pwm_duty_decoder;

    localparam int CNT_W   = 9;
    localparam int SYNC    = 2;
    localparam int NEG_TOL = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             pwm_in;
    logic             pwm_neg_in;
    logic             pwm_d = 1'b0;
    logic             neg_mode;
    logic             neg_watch;
    logic [CNT_W-1:0] duty_out;
    logic [CNT_W-1:0] period_out;
    logic             valid_out;
    logic             stuck_out;
    logic             level_out;
    logic             neg_err_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit neg_seen = 1'b0;

    typedef struct {
        int duty;
        int period;
        int stuck;
        int cyc;
    } ev_t;

    ev_t q[$];
    int  rises[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        pwm_d <= pwm_in;
    end

    assign pwm_neg_in = neg_mode ? pwm_in : ~pwm_d;

    pwm_duty_decoder #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC),
        .NEG_TOL     (NEG_TOL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pwm_in      (pwm_in),
        .pwm_neg_in  (pwm_neg_in),
        .duty_out    (duty_out),
        .period_out  (period_out),
        .valid_out   (valid_out),
        .stuck_out   (stuck_out),
        .level_out   (level_out),
        .neg_err_out (neg_err_out)
    );

    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            q.push_back('{int'(duty_out), int'(period_out), int'(stuck_out), cyc});
        end
        if (neg_watch && neg_err_out !== 1'b0) begin
            neg_seen = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pwm_period(input int h, input int p);
        for (int i = 0; i < p; i++) begin
            pwm_in = (i < h);
            if (i == 0) rises.push_back(cyc);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic settle(input int n);
        pwm_in = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        pwm_in    = 1'b0;
        neg_watch = 1'b1;
`ifdef PWM_DEC_NEG_CHECK_EN
        neg_mode  = 1'b0;
`else
        neg_mode  = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_duty", 32'(duty_out), 0);
        chk("reset_period", 32'(period_out), 0);
        chk("reset_valid", 32'(valid_out), 0);
        chk("reset_stuck", 32'(stuck_out), 0);
        chk("reset_level", 32'(level_out), 0);
        chk("reset_neg_err", 32'(neg_err_out), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Steady 64/256 stream; first rise only arms the measurement.
        q.delete();
        rises.delete();
        pwm_period(64, 256);
        chk("first_rise_no_strobe", 32'(q.size()), 0);
        repeat (3) pwm_period(64, 256);
        settle(4);
        chk("steady_strobe_count", 32'(q.size()), 3);
        for (int k = 0; k < 3 && k < q.size(); k++) begin
            chk("steady_duty", 32'(q[k].duty), 64);
            chk("steady_period", 32'(q[k].period), 256);
            chk("steady_stuck", 32'(q[k].stuck), 0);
            chk("steady_latency", 32'(q[k].cyc), 32'(rises[k+1] + SYNC + 1));
        end

        // Duty change at a period boundary, then the 1/3 corner.
        q.delete();
        repeat (2) pwm_period(192, 256);
        repeat (3) pwm_period(1, 3);
        settle(4);
        chk("change_strobe_count", 32'(q.size()), 5);
        if (q.size() == 5) begin
            chk("h192_duty", 32'(q[1].duty), 192);
            chk("h192_period", 32'(q[1].period), 256);
            chk("h192_stuck", 32'(q[1].stuck), 0);
            chk("h1_duty_a", 32'(q[3].duty), 1);
            chk("h1_period_a", 32'(q[3].period), 3);
            chk("h1_duty_b", 32'(q[4].duty), 1);
            chk("h1_period_b", 32'(q[4].period), 3);
        end
        chk("change_stuck_out", 32'(stuck_out), 0);

        // Stuck low: exactly one timeout strobe.
        q.delete();
        pwm_in = 1'b0;
        repeat (700) @(posedge clk);
        #1;
        chk("stuck_low_count", 32'(q.size()), 1);
        if (q.size() == 1) begin
            chk("stuck_low_period", 32'(q[0].period), 0);
            chk("stuck_low_duty", 32'(q[0].duty), 0);
            chk("stuck_low_stuck", 32'(q[0].stuck), 1);
        end
        chk("stuck_low_flag", 32'(stuck_out), 1);

        // Stuck high: duty reports all-ones.
        q.delete();
        pwm_in = 1'b1;
        repeat (700) @(posedge clk);
        #1;
        settle(10);
        chk("stuck_high_count", 32'(q.size()), 1);
        if (q.size() == 1) begin
            chk("stuck_high_period", 32'(q[0].period), 0);
            chk("stuck_high_duty", 32'(q[0].duty), 511);
            chk("stuck_high_stuck", 32'(q[0].stuck), 1);
        end
        chk("stuck_high_level", 32'(level_out), 0);

        // Recovery: stuck clears only at the second rise.
        q.delete();
        pwm_period(64, 256);
        chk("recover_first_no_strobe", 32'(q.size()), 0);
        chk("recover_stuck_held", 32'(stuck_out), 1);
        repeat (2) pwm_period(64, 256);
        settle(4);
        chk("recover_count", 32'(q.size()), 2);
        if (q.size() == 2) begin
            chk("recover_duty", 32'(q[0].duty), 64);
            chk("recover_period", 32'(q[0].period), 256);
            chk("recover_stuck", 32'(q[0].stuck), 0);
        end
        chk("recover_stuck_out", 32'(stuck_out), 0);

        // Reset 100 cycles into a period.
        pwm_in = 1'b1;
        repeat (64) @(posedge clk);
        #1;
        pwm_in = 1'b0;
        repeat (36) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_duty", 32'(duty_out), 0);
        chk("midreset_period", 32'(period_out), 0);
        chk("midreset_valid", 32'(valid_out), 0);
        chk("midreset_stuck", 32'(stuck_out), 0);
        chk("midreset_level", 32'(level_out), 0);
        reset = 1'b0;
        q.delete();
        repeat (150) @(posedge clk);
        #1;
        pwm_period(64, 256);
        chk("postreset_first_no_strobe", 32'(q.size()), 0);
        pwm_period(64, 256);
        settle(4);
        chk("postreset_count", 32'(q.size()), 1);
        if (q.size() == 1) begin
            chk("postreset_duty", 32'(q[0].duty), 64);
            chk("postreset_period", 32'(q[0].period), 256);
        end

        neg_watch = 1'b0;
        chk("neg_err_never_seen", 32'(neg_seen), 0);
`ifdef PWM_DEC_NEG_CHECK_EN
        neg_mode = 1'b1;
        pwm_in   = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("neg_equal_err", 32'(neg_err_out), 1);
        neg_mode = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("neg_err_sticky", 32'(neg_err_out), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("neg_err_reset", 32'(neg_err_out), 0);
        reset = 1'b0;
`else
        chk("neg_err_tied", 32'(neg_err_out), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
